// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit
// (master) and the instruction memory (slave).
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req_valid;
  logic [ADDR_W-1:0]  req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [INSTR_W-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: holds the architectural PC, issues one word fetch per PC
// over a valid/ready channel, and buffers returned words in a 2-entry
// fall-through FIFO toward decode. A redirect flushes all in-flight work.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_pc_i,
  input  logic               redirect_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  pc_fetch_unit_if.master    imem,
  output logic               id_valid_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc_o,
  input  logic               id_ready_i
);

  // Word alignment: the two low PC bits are forced to zero everywhere.
  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;

  logic [INSTR_W-1:0] r_fifo_data [2];
  logic [ADDR_W-1:0]  r_fifo_pc   [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;

  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_push;
  logic               w_pop;

  // Only ISSUE can have a request in flight of zero, so the occupancy test
  // reduces to the FIFO count. Redirect and reset suppress the request so no
  // handshake can happen on a PC that is being replaced.
  assign w_req_valid = !rst && !redirect_i && (r_state == ST_ISSUE) && (r_count != 2'd2);
  assign w_req_fire  = w_req_valid && imem.req_ready;
  assign w_push      = (r_state == ST_WAIT) && imem.resp_valid && !redirect_i;
  assign w_pop       = (r_count != 2'd0) && id_ready_i && !redirect_i;

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = r_pc;
  assign pc_o           = r_pc;
  assign pc_plus4_o     = r_pc + ADDR_W'(4);
  assign id_valid_o     = (r_count != 2'd0);
  assign id_instr_o     = r_fifo_data[r_rd_ptr];
  assign id_pc_o        = r_fifo_pc[r_rd_ptr];

  // Fetch FSM and PC register; redirect overrides every other transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ISSUE;
      r_pc     <= RESET_PC & PC_ALIGN_MASK;
      r_req_pc <= RESET_PC & PC_ALIGN_MASK;
    end else if (redirect_i) begin
      r_pc <= next_pc_i & PC_ALIGN_MASK;
      if ((r_state == ST_WAIT) || (r_state == ST_DROP)) begin
        // A response arriving now belongs to the flushed path; either it
        // is dropped here or the next one will be dropped in DROP.
        r_state <= imem.resp_valid ? ST_ISSUE : ST_DROP;
      end else begin
        r_state <= ST_ISSUE;
      end
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_req_fire) begin
            r_state  <= ST_WAIT;
            r_req_pc <= r_pc;
            r_pc     <= next_pc_i & PC_ALIGN_MASK;
          end
        end
        ST_WAIT: begin
          if (imem.resp_valid) r_state <= ST_ISSUE;
        end
        ST_DROP: begin
          if (imem.resp_valid) r_state <= ST_ISSUE;
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

  // FIFO storage: write the returned word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem.resp_data;
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. A driver process acts as the
// instruction memory and the PC-mux, keeping a program-order model of the
// fetch stream; a monitor process checks PC, request and decode outputs.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc_i;
  logic        redirect_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) imem_bus ();

  pc_fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc_i  (next_pc_i),
    .redirect_i (redirect_i),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .imem       (imem_bus),
    .id_valid_o (id_valid_o),
    .id_instr_o (id_instr_o),
    .id_pc_o    (id_pc_o),
    .id_ready_i (id_ready_i)
  );

  always #5 clk = ~clk;

  // Scoreboard: instructions expected at decode, in order.
  entry_t      exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Per-cycle expectations published by the driver for the monitor.
  bit          s_go      = 1'b0;
  bit          s_rst     = 1'b0;
  bit          s_exp_req = 1'b0;
  logic [31:0] s_exp_pc  = '0;

  // Model state: architectural PC and the single outstanding memory request.
  logic [31:0] m_pc   = '0;
  logic [31:0] m_addr = '0;
  bit          m_out  = 1'b0;
  bit          m_drop = 1'b0;
  int          m_rem  = 0;

  // Stimulus knobs (percent probabilities and memory latency range).
  int          p_ready = 100;
  int          p_idr   = 100;
  int          p_redir = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt   = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the matching model update.
  task automatic do_cycle(input bit do_rst);
    logic [31:0] tgt;
    logic [1:0]  junk;
    bit          redir;
    bit          ready;
    bit          idr;
    bit          resp;
    bit          hs;
    tgt   = '0;
    resp  = 1'b0;
    redir = 1'b0;
    @(negedge clk);
    if (!do_rst && m_out) begin
      if (m_rem <= 1) resp = 1'b1;
      else m_rem--;
    end
    if (!do_rst) begin
      if (force_redir) begin
        redir       = 1'b1;
        tgt         = force_tgt;
        force_redir = 1'b0;
      end else if ($urandom_range(99) < p_redir) begin
        redir = 1'b1;
        tgt   = $urandom;
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF8 | (tgt & 32'h7);
      end
    end
    ready = ($urandom_range(99) < p_ready);
    idr   = ($urandom_range(99) < p_idr);
    junk  = 2'($urandom_range(3));

    s_exp_req = !do_rst && !redir && !m_out && (exp_q.size() < 2);
    s_exp_pc  = m_pc;
    s_rst     = do_rst;
    s_go      = 1'b1;
    hs        = s_exp_req && ready;

    rst                 = do_rst;
    redirect_i          = redir;
    next_pc_i           = redir ? tgt : ((m_pc + 32'd4) | {30'd0, junk});
    imem_bus.req_ready  = ready;
    imem_bus.resp_valid = resp;
    imem_bus.resp_data  = resp ? mem_word(m_addr) : $urandom;
    id_ready_i          = idr;

    #3;
    if (do_rst) begin
      exp_q.delete();
      m_pc   = 32'h0;
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else begin
      if (resp) begin
        m_out = 1'b0;
        if (!redir && !m_drop) exp_q.push_back('{pc: m_addr, data: mem_word(m_addr)});
      end
      if (redir) begin
        exp_q.delete();
        if (m_out) m_drop = 1'b1;
        m_pc = tgt & 32'hFFFF_FFFC;
      end
      if (hs) begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_addr = m_pc;
        m_rem  = $urandom_range(lat_max, lat_min);
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  // Monitor: compares DUT outputs with the model once inputs have settled.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (s_go) begin
        if (s_rst) begin
          chk("req_valid_in_reset", 32'(imem_bus.req_valid), 32'd0);
        end else begin
          chk("pc_o", pc_o, s_exp_pc);
          chk("pc_plus4_o", pc_plus4_o, s_exp_pc + 32'd4);
          chk("req_valid", 32'(imem_bus.req_valid), 32'(s_exp_req));
          if (s_exp_req) chk("req_addr", imem_bus.req_addr, s_exp_pc);
          chk("id_valid", 32'(id_valid_o), 32'(exp_q.size() != 0));
          if (id_valid_o && id_ready_i && !redirect_i && (exp_q.size() != 0)) begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc_o, e.pc);
            chk("id_instr", id_instr_o, e.data);
            $display("[TB] decode pc=%h instr=%h", id_pc_o, id_instr_o);
          end
        end
      end
    end
  end

  // Stimulus sequence: directed scenarios followed by a randomized run.
  initial begin
    rst                 = 1'b1;
    redirect_i          = 1'b0;
    next_pc_i           = '0;
    id_ready_i          = 1'b0;
    imem_bus.req_ready  = 1'b0;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = '0;

    do_cycle(1'b1);
    do_cycle(1'b1);

    // Sequential fetch with single-cycle memory and a ready decoder.
    repeat (12) do_cycle(1'b0);

    // Decode stall fills the FIFO, then releases.
    p_idr = 0;
    repeat (10) do_cycle(1'b0);
    p_idr = 100;
    repeat (8) do_cycle(1'b0);

    // Redirect while a slow fetch is outstanding.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 10 && !m_out; i++) do_cycle(1'b0);
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0100;
    do_cycle(1'b0);
    repeat (10) do_cycle(1'b0);

    // Redirect coincident with a response and a decode pop.
    lat_min = 1;
    lat_max = 1;
    p_idr   = 0;
    for (int i = 0; i < 20 && !(m_out && m_rem == 1 && exp_q.size() != 0); i++) do_cycle(1'b0);
    p_idr       = 100;
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0200;
    do_cycle(1'b0);
    repeat (6) do_cycle(1'b0);

    // Memory not ready: request held, then a misaligned redirect target.
    p_ready = 0;
    repeat (5) do_cycle(1'b0);
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0103;
    do_cycle(1'b0);
    p_ready = 100;
    repeat (6) do_cycle(1'b0);

    // PC wrap-around at the top of the address space.
    force_redir = 1'b1;
    force_tgt   = 32'hFFFF_FFFC;
    do_cycle(1'b0);
    repeat (10) do_cycle(1'b0);

    // Randomized mix of back-pressure, latency and redirects.
    p_ready = 70;
    p_idr   = 60;
    p_redir = 8;
    lat_min = 1;
    lat_max = 4;
    repeat (600) do_cycle(1'b0);

    // Reset in the middle of traffic, then continue.
    do_cycle(1'b1);
    repeat (200) do_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
